// File: rtl/serial_tx_arb_pkg.sv
// Shared constants and helpers for the UART_TX pin arbiter.
// Owner codes are source index + 1; zero means the pin is free.
package serial_tx_arb_pkg;

    localparam int unsigned SRC_TAPE = 0;
    localparam int unsigned SRC_MIDI = 1;
    localparam int unsigned SRC_UART = 2;
    localparam int unsigned N_SRC    = 3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_TAPE = 2'd1;
    localparam logic [1:0] OWN_MIDI = 2'd2;
    localparam logic [1:0] OWN_UART = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;

    // Highest index wins: uart > midi > tape.
    function automatic logic [1:0] pick_winner(input logic [N_SRC-1:0] edges);
        logic [1:0] win;
        win = OWN_NONE;
        if (edges[SRC_UART]) begin
            win = OWN_UART;
        end else if (edges[SRC_MIDI]) begin
            win = OWN_MIDI;
        end else if (edges[SRC_TAPE]) begin
            win = OWN_TAPE;
        end
        return win;
    endfunction

    function automatic logic [N_SRC-1:0] owner_mask(input logic [1:0] own);
        logic [N_SRC-1:0] m;
        m = '0;
        unique case (own)
            OWN_TAPE: m = 3'b001;
            OWN_MIDI: m = 3'b010;
            OWN_UART: m = 3'b100;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_idle_timer.sv
// ce-gated idle counter; pulses expire on the terminal tick unless cleared.
// Never wraps: holds at the terminal value until clear or expiry.
module arb_idle_timer #(
    parameter int unsigned IDLE_TICKS = 16384,
    parameter int unsigned CNT_W      = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic ce_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(IDLE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term  = (cnt_q == TERM);
    assign expire_o = ce_i & ~clear_i & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (ce_i) begin
            cnt_d = at_term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares the board UART_TX pin between tape, MIDI and UART serial sources.
// First toggling source owns the pin until it stays silent for IDLE_TICKS ce.
module serial_tx_arbiter
    import serial_tx_arb_pkg::*;
#(
    parameter int unsigned IDLE_TICKS = 16384,
    parameter int unsigned CNT_W      = 15
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [2:0] src_in,
    input  logic [2:0] src_en,
    output logic       tx_out,
    output logic [1:0] owner,
    output logic       busy,
    output logic       collision,
    output logic [7:0] collision_cnt
);

    arb_state_e state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       tx_q, tx_d;
    logic       coll_q, coll_d;
    logic [7:0] ccnt_q, ccnt_d;
    logic [2:0] prev_q;

    logic [2:0] src_edge;
    logic [2:0] own_m;
    logic [1:0] win;
    logic       own_edge;
    logic       own_en;
    logic       own_bit;
    logic       other_edge;
    logic       tmr_clear;
    logic       tmr_expire;

    assign src_edge   = src_en & (src_in ^ prev_q);
    assign own_m      = owner_mask(owner_q);
    assign win        = pick_winner(src_edge);
    assign own_edge   = |(src_edge & own_m);
    assign own_en     = |(src_en & own_m);
    assign own_bit    = |(src_in & own_m);
    assign other_edge = |(src_edge & ~own_m);

    // Counter is held at zero whenever the pin is free or about to be freed.
    assign tmr_clear = (state_q == ST_IDLE) | own_edge | ~own_en;

    arb_idle_timer #(
        .IDLE_TICKS (IDLE_TICKS),
        .CNT_W      (CNT_W)
    ) u_idle_timer (
        .clk_i    (clk_sys),
        .reset_i  (reset),
        .clear_i  (tmr_clear),
        .ce_i     (ce),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tx_d    = tx_q;
        coll_d  = 1'b0;
        ccnt_d  = ccnt_q;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (|src_edge) begin
                    state_d = ST_OWNED;
                    owner_d = win;
                    tx_d    = |(src_in & owner_mask(win));
                end
            end
            ST_OWNED: begin
                // Release cycle drops every other edge: no claim, no collision.
                if (!own_en || tmr_expire) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = own_bit;
                    if (other_edge) begin
                        coll_d = 1'b1;
                        if (ccnt_q != 8'hFF) begin
                            ccnt_d = ccnt_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        prev_q <= src_in;
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            tx_q    <= 1'b1;
            coll_q  <= 1'b0;
            ccnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tx_q    <= tx_d;
            coll_q  <= coll_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign tx_out        = tx_q;
    assign owner         = owner_q;
    assign busy          = (owner_q != OWN_NONE);
    assign collision     = coll_q;
    assign collision_cnt = ccnt_q;

endmodule
